// File: rtl/motor_ramp_pwm.sv
// motor_ramp_pwm
//   Slews the motor speed toward an RPM setpoint at a bounded rate per ramp
//   tick, reports ramp status, and drives a glitch-free PWM whose duty (in
//   clocks per RPM_MAX-clock period) equals the slewed speed.
//
// Parameters
//   TICK_DIV   clocks per ramp update tick (>= 2)
//   RAMP_STEP  maximum |delta rpm| per tick
//   RPM_MAX    speed ceiling and PWM period in clocks
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   enable      in   1 = track target_rpm, 0 = soft stop (ramp to 0)
//   target_rpm  in   RPM setpoint
//   cur_rpm     out  current slewed speed
//   pwm_out     out  registered PWM drive
//   at_target   out  1 in IDLE or HOLD
//   state       out  0 IDLE, 1 RAMP_UP, 2 RAMP_DN, 3 HOLD
module motor_ramp_pwm #(
  parameter int          TICK_DIV  = 10,
  parameter logic [15:0] RAMP_STEP = 16'd300,
  parameter logic [15:0] RPM_MAX   = 16'd6000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] target_rpm,
  output logic [15:0] cur_rpm,
  output logic        pwm_out,
  output logic        at_target,
  output logic [1:0]  state
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]   PWM_LAST  = RPM_MAX - 16'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // Ramp tick generator
  // ---------------------------------------------------------------------
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  // ---------------------------------------------------------------------
  // Effective target and slew arithmetic
  // ---------------------------------------------------------------------
  logic [15:0] tgt_clamp, eff;
  logic [15:0] cur_q, cur_d;
  logic [16:0] up_sum;    // cur + step, can exceed 16 bits
  logic [16:0] dn_floor;  // eff + step: below this, one step would pass eff

  assign tgt_clamp = (target_rpm > RPM_MAX) ? RPM_MAX : target_rpm;
  assign eff       = enable ? tgt_clamp : 16'd0;
  assign up_sum    = {1'b0, cur_q} + {1'b0, RAMP_STEP};
  assign dn_floor  = {1'b0, eff}   + {1'b0, RAMP_STEP};

  always_comb begin
    cur_d = cur_q;
    if (tick) begin
      if (cur_q < eff) begin
        cur_d = (up_sum >= {1'b0, eff}) ? eff : up_sum[15:0];
      end else if (cur_q > eff) begin
        // Comparing against eff+step avoids ever forming cur-step below 0.
        cur_d = ({1'b0, cur_q} <= dn_floor) ? eff : (cur_q - RAMP_STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_q <= 16'd0;
    else       cur_q <= cur_d;
  end

  // ---------------------------------------------------------------------
  // Ramp status FSM: re-evaluated only on ticks from the new speed
  // ---------------------------------------------------------------------
  state_e state_q, state_d;
  logic   at_target_q, at_target_d;

  always_comb begin
    state_d     = state_q;
    at_target_d = at_target_q;
    if (tick) begin
      if (cur_d == eff)     state_d = (eff == 16'd0) ? IDLE : HOLD;
      else if (cur_d < eff) state_d = RAMP_UP;
      else                  state_d = RAMP_DN;
      at_target_d = (state_d == IDLE) || (state_d == HOLD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      at_target_q <= at_target_d;
    end
  end

  // ---------------------------------------------------------------------
  // PWM: duty only reloads at the period boundary so a period is never cut
  // ---------------------------------------------------------------------
  logic [15:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0] duty_q, duty_d;
  logic        pwm_q, pwm_d;
  logic        pwm_wrap;

  assign pwm_wrap  = (pwm_cnt_q == PWM_LAST);
  assign pwm_cnt_d = pwm_wrap ? 16'd0 : pwm_cnt_q + 16'd1;
  assign duty_d    = pwm_wrap ? cur_q : duty_q;
  // Counter never reaches RPM_MAX, so duty == RPM_MAX is high all period.
  assign pwm_d     = (pwm_cnt_d < duty_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= 16'd0;
      duty_q    <= 16'd0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end

  assign cur_rpm   = cur_q;
  assign pwm_out   = pwm_q;
  assign at_target = at_target_q;
  assign state     = state_q;

endmodule
